axis_tx_framer: RTL and testbench
=================================

// Module: axis_tx_framer
// PURPOSE
//  AXI-Stream byte source to 8b/10b encoder framer; sits directly upstream of encoder_8b10.
//  Wraps each packet as K27.7 (SOF), data bytes, K29.7 (EOF).
//  Fills gaps with K28.5 idle commas between packets and K23.7 filler inside a packet.
//  Emits one symbol per downstream request (sym_req from the serializer).
// PARAMETERS
//  MIN_IDLE   4   minimum K28.5 symbols sent after EOF (and after reset) before the next SOF; 0 allowed
// PORTS
//  clk            in   1  system clock
//  rst_n          in   1  asynchronous active-low reset
//  s_axis_tdata   in   8  payload byte
//  s_axis_tvalid  in   1  payload valid
//  s_axis_tlast   in   1  last byte of packet
//  s_axis_tready  out  1  byte accepted this cycle
//  sym_req        in   1  serializer requests next symbol (1-cycle strobe; may be high every cycle)
//  enc_en         out  1  to encoder en; registered copy of sym_req
//  enc_kin        out  1  to encoder kin
//  enc_din        out  8  to encoder din
//  frame_active   out  1  state is DATA or EOF
//  underrun       out  1  1-cycle pulse: K23.7 filler emitted inside a frame
// BEHAVIOUR
//  - One clock domain. Reset is asynchronous and active-low; rst_n low forces:
//    state=IDLE, idle_cnt=0, enc_en=0, enc_kin=0, enc_din=8'h00, underrun=0.
//  - Latency: a symbol is chosen in the sym_req cycle and registered; at the next edge
//    enc_en=1 and enc_din/enc_kin hold it. Both hold their value until the next sym_req.
//  - enc_en=0 in every cycle that does not follow a sym_req.
//  - s_axis_tready = sym_req & (state==DATA) (combinational); a byte moves only on tvalid&tready.
//  - FSM, advancing only on sym_req:
//    IDLE: if idle_cnt>=MIN_IDLE and tvalid, emit K27.7 (FB,k=1) and go to DATA.
//          Otherwise emit K28.5 (BC,k=1) and increment idle_cnt, saturating at MIN_IDLE.
//    DATA: if tvalid, emit tdata (k=0); if tlast also set, go to EOF.
//          If !tvalid, emit K23.7 (F7,k=1), pulse underrun, stay in DATA.
//    EOF:  emit K29.7 (FD,k=1), clear idle_cnt, go to IDLE.
//  - SOF does not consume a byte: the first payload byte is sent at the next sym_req.
//  - A tlast on a single-byte packet gives the sequence SOF, D, EOF.
//  - With MIN_IDLE=0 packets run back-to-back: EOF, SOF, ... with no K28.5 between them.
//  - When sym_req is low the FSM holds, tready is 0, and AXIS data waits (the source holds it per AXIS).
//  - tvalid rising in IDLE before idle_cnt reaches MIN_IDLE: K28.5 continues until it does.
//  - Reset mid-frame: the frame is abandoned, no EOF is sent; after reset, MIN_IDLE commas precede any SOF.
//  - idle_cnt width = $clog2(MIN_IDLE+1), minimum 1 bit; it never wraps.
//  - K-code legality: only K28.5/K27.7/K29.7/K23.7 are ever driven with kin=1,
//    so the encoder's kin_err must stay 0.
// STRUCTURE
//  - Shared package axis_serdes_pkg holds:
//    K28_5=8'hBC, K27_7=8'hFB, K29_7=8'hFD, K23_7=8'hF7, and the state enum {IDLE,DATA,EOF}.
//  - The decoder-side deframer reuses these constants.
//  - No sub-module: a single FSM with an idle counter and an output register.
// TESTING
//  1 Reset release, sym_req held 1, no traffic -> enc_en=1 every cycle from cycle 2;
//    stream BC,k=1 continuously; frame_active=0.
//  2 MIN_IDLE=4; 3-byte packet 11,22,33(tlast) offered at cycle 0, sym_req=1 ->
//    4xBC, FB, 11, 22, 33(k=0), FD, then BC; tready high on exactly 3 cycles.
//  3 tvalid drops for 2 sym_reqs mid-packet -> two F7,k=1 symbols; underrun pulses twice;
//    byte order is preserved.
//  4 sym_req every 10th cycle -> enc_en pulses one cycle after each sym_req;
//    enc_din is stable between pulses; tready is never high without sym_req.
//  5 MIN_IDLE=0, two back-to-back 1-byte packets (AA tlast, BB tlast) -> FB, AA, FD, FB, BB, FD.
//  6 rst_n asserted asynchronously mid-DATA -> outputs zero immediately;
//    after release, 4xBC before the next FB. Check the encoder's kin_err=0 throughout.

Source files
------------

// File: rtl/axis_serdes_pkg.sv
// Shared 8b/10b framing symbols and framer state encoding.
// Used by the TX framer and the decoder-side deframer.
package axis_serdes_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K23_7 = 8'hF7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    EOF  = 2'd2
  } state_e;

endpackage

// File: rtl/axis_tx_framer_if.sv
// AXI-Stream byte channel feeding the TX framer.
// Ports: tdata/tvalid/tlast from master, tready from slave.
interface axis_tx_framer_if;

  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/axis_tx_framer.sv
// AXIS byte stream to 8b/10b symbol framer: SOF/data/EOF, idles, filler.
// Ports: clk, rst_n, s_axis_*, sym_req in; enc_en/kin/din, frame_active, underrun out.
module axis_tx_framer #(
  parameter int MIN_IDLE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  input  logic       s_axis_tlast,
  output logic       s_axis_tready,
  input  logic       sym_req,
  output logic       enc_en,
  output logic       enc_kin,
  output logic [7:0] enc_din,
  output logic       frame_active,
  output logic       underrun
);

  import axis_serdes_pkg::*;

  localparam int CW =
    (MIN_IDLE > 0) ? $clog2(MIN_IDLE + 1) : 1;
  localparam logic [CW-1:0] MIN_V = CW'(MIN_IDLE);

  state_e          state_q, state_d;
  logic [CW-1:0]   idle_cnt_q, idle_cnt_d;
  logic            en_q, en_d;
  logic            kin_q, kin_d;
  logic [7:0]      din_q, din_d;
  logic            underrun_q, underrun_d;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    en_d       = sym_req;
    kin_d      = kin_q;
    din_d      = din_q;
    underrun_d = 1'b0;
    if (sym_req) begin
      unique case (state_q)
        IDLE: begin
          if (idle_cnt_q >= MIN_V && s_axis_tvalid) begin
            kin_d   = 1'b1;
            din_d   = K27_7;
            state_d = DATA;
          end else begin
            kin_d = 1'b1;
            din_d = K28_5;
            if (idle_cnt_q < MIN_V)
              idle_cnt_d = idle_cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (s_axis_tvalid) begin
            kin_d = 1'b0;
            din_d = s_axis_tdata;
            if (s_axis_tlast)
              state_d = EOF;
          end else begin
            kin_d      = 1'b1;
            din_d      = K23_7;
            underrun_d = 1'b1;
          end
        end
        EOF: begin
          kin_d      = 1'b1;
          din_d      = K29_7;
          idle_cnt_d = '0;
          state_d    = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idle_cnt_q <= '0;
      en_q       <= 1'b0;
      kin_q      <= 1'b0;
      din_q      <= 8'h00;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      en_q       <= en_d;
      kin_q      <= kin_d;
      din_q      <= din_d;
      underrun_q <= underrun_d;
    end
  end

  assign s_axis_tready = sym_req & (state_q == DATA);
  assign enc_en        = en_q;
  assign enc_kin       = kin_q;
  assign enc_din       = din_q;
  assign underrun      = underrun_q;
  assign frame_active  = (state_q == DATA) | (state_q == EOF);

endmodule

// File: tb/tb_axis_tx_framer.sv
// Scoreboard bench for axis_tx_framer (MIN_IDLE=4 and MIN_IDLE=0).
// Expected symbols are queued with stimulus and popped on enc_en.
module tb_axis_tx_framer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_tx_framer_if ax4 ();
  axis_tx_framer_if ax0 ();

  logic       sel = 1'b0;
  logic       req_v = 1'b0;
  logic [7:0] tdata_v = 8'h00;
  logic       tvalid_v = 1'b0;
  logic       tlast_v = 1'b0;

  logic       req4, req0;
  logic       en4, kin4, fa4, und4;
  logic       en0, kin0, fa0, und0;
  logic [7:0] din4, din0;

  assign ax4.tdata  = tdata_v;
  assign ax4.tvalid = tvalid_v;
  assign ax4.tlast  = tlast_v;
  assign ax0.tdata  = tdata_v;
  assign ax0.tvalid = tvalid_v;
  assign ax0.tlast  = tlast_v;
  assign req4 = req_v & ~sel;
  assign req0 = req_v & sel;

  axis_tx_framer #(.MIN_IDLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(ax4.tdata), .s_axis_tvalid(ax4.tvalid),
    .s_axis_tlast(ax4.tlast), .s_axis_tready(ax4.tready),
    .sym_req(req4), .enc_en(en4), .enc_kin(kin4),
    .enc_din(din4), .frame_active(fa4), .underrun(und4)
  );

  axis_tx_framer #(.MIN_IDLE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(ax0.tdata), .s_axis_tvalid(ax0.tvalid),
    .s_axis_tlast(ax0.tlast), .s_axis_tready(ax0.tready),
    .sym_req(req0), .enc_en(en0), .enc_kin(kin0),
    .enc_din(din0), .frame_active(fa0), .underrun(und0)
  );

  logic       en_v, kin_v, fa_v, und_v, tready_v;
  logic [7:0] din_v;
  assign en_v     = sel ? en0 : en4;
  assign kin_v    = sel ? kin0 : kin4;
  assign din_v    = sel ? din0 : din4;
  assign fa_v     = sel ? fa0 : fa4;
  assign und_v    = sel ? und0 : und4;
  assign tready_v = sel ? ax0.tready : ax4.tready;

  int n_chk = 0;
  int n_pass = 0;

  logic [8:0] exp_q[$];
  logic [8:0] src[$];
  logic [8:0] last_sym;
  int period, cyc, acc, gap_at, gap_left, tr_cnt, und_cnt;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic push(logic k, logic [7:0] d);
    exp_q.push_back({k, d});
  endtask

  task automatic push_bc(int n);
    for (int i = 0; i < n; i++) push(1'b1, 8'hBC);
  endtask

  task automatic do_reset();
    req_v    = 1'b0;
    tvalid_v = 1'b0;
    tdata_v  = 8'h00;
    tlast_v  = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("rst_en", en_v, 0);
    check("rst_kin", kin_v, 0);
    check("rst_din", din_v, 0);
    check("rst_und", und_v, 0);
    check("rst_fa", fa_v, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    last_sym = '0;
    cyc      = 0;
    acc      = 0;
    gap_left = 0;
    tr_cnt   = 0;
    und_cnt  = 0;
    src.delete();
    exp_q.delete();
  endtask

  task automatic run(int n);
    logic [8:0] e;
    logic gap;
    for (int c = 0; c < n; c++) begin
      req_v = (cyc % period) == 0;
      cyc++;
      gap = (gap_left > 0) && (acc == gap_at);
      if (src.size() > 0 && !gap) begin
        tvalid_v = 1'b1;
        {tlast_v, tdata_v} = src[0];
      end else begin
        tvalid_v = 1'b0;
        tlast_v  = 1'b0;
        tdata_v  = 8'h00;
      end
      if (req_v && gap && src.size() > 0) gap_left--;
      #1;
      if (!req_v) check("tready_noreq", tready_v, 0);
      if (tvalid_v && tready_v) begin
        void'(src.pop_front());
        acc++;
        tr_cnt++;
      end
      @(posedge clk);
      #1;
      check("en_follows_req", en_v, req_v);
      if (en_v) begin
        if (kin_v)
          check("kin_err",
                (din_v inside {8'hBC, 8'hFB, 8'hFD, 8'hF7}) ? 0 : 1, 0);
        if (und_v) und_cnt++;
        if (exp_q.size() == 0) begin
          check("sb_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sym", {kin_v, din_v}, e);
          check("underrun", und_v, e == 9'h1F7);
          check("frame_active", fa_v,
                !(e == 9'h1BC || e == 9'h1FD));
        end
        last_sym = {kin_v, din_v};
      end else begin
        check("din_hold", {kin_v, din_v}, last_sym);
        check("und_idle", und_v, 0);
      end
    end
  endtask

  initial begin
    period   = 1;
    last_sym = '0;

    // 1: idle commas after reset
    do_reset();
    push_bc(8);
    run(8);
    check("t1_drain", exp_q.size(), 0);

    // 2: three-byte packet behind MIN_IDLE commas
    do_reset();
    src.push_back(9'h011);
    src.push_back(9'h022);
    src.push_back(9'h133);
    push_bc(4);
    push(1, 8'hFB); push(0, 8'h11); push(0, 8'h22);
    push(0, 8'h33); push(1, 8'hFD);
    push_bc(3);
    run(12);
    check("t2_drain", exp_q.size(), 0);
    check("t2_tready_cnt", tr_cnt, 3);

    // 3: source stalls two symbols mid-packet
    do_reset();
    src.push_back(9'h044);
    src.push_back(9'h055);
    src.push_back(9'h166);
    gap_at = 1;
    gap_left = 2;
    push_bc(4);
    push(1, 8'hFB); push(0, 8'h44);
    push(1, 8'hF7); push(1, 8'hF7);
    push(0, 8'h55); push(0, 8'h66); push(1, 8'hFD);
    push_bc(1);
    run(12);
    check("t3_drain", exp_q.size(), 0);
    check("t3_und_cnt", und_cnt, 2);

    // 4: sparse symbol requests
    do_reset();
    period = 10;
    src.push_back(9'h077);
    src.push_back(9'h188);
    push_bc(4);
    push(1, 8'hFB); push(0, 8'h77); push(0, 8'h88);
    push(1, 8'hFD);
    push_bc(7);
    run(150);
    check("t4_drain", exp_q.size(), 0);
    check("t4_tready_cnt", tr_cnt, 2);
    period = 1;

    // 5: MIN_IDLE=0 back-to-back single-byte packets
    sel = 1'b1;
    do_reset();
    src.push_back(9'h1AA);
    src.push_back(9'h1BB);
    push(1, 8'hFB); push(0, 8'hAA); push(1, 8'hFD);
    push(1, 8'hFB); push(0, 8'hBB); push(1, 8'hFD);
    push_bc(1);
    run(7);
    check("t5_drain", exp_q.size(), 0);
    sel = 1'b0;

    // 6: asynchronous reset in the middle of a frame
    do_reset();
    for (int i = 1; i <= 5; i++)
      src.push_back({i == 5, 8'(i)});
    push_bc(4);
    push(1, 8'hFB); push(0, 8'h01); push(0, 8'h02);
    run(7);
    check("t6_pre_drain", exp_q.size(), 0);
    check("t6_fa_mid", fa_v, 1);
    #3;
    do_reset();
    src.push_back(9'h109);
    push_bc(4);
    push(1, 8'hFB); push(0, 8'h09); push(1, 8'hFD);
    push_bc(1);
    run(8);
    check("t6_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
